// File: rtl/rr_packet_dispatcher_if.sv
// Ingress/egress bundle for rr_packet_dispatcher: framed byte stream in, shared data bus
// with one-hot per-channel valid out, plus status pulses.
interface rr_packet_dispatcher_if #(
   parameter int CHN_NUM = 8,
   parameter int CHN_W   = 3,
   parameter int DATA_W  = 8
);
   logic [DATA_W-1:0]  din;
   logic               din_vld;
   logic               din_sop;
   logic               din_eop;
   logic               din_rdy;
   logic [CHN_NUM-1:0] chn_rdy;
   logic [DATA_W-1:0]  dout;
   logic [CHN_NUM-1:0] dout_vld;
   logic               dout_sop;
   logic               dout_eop;
   logic [CHN_W-1:0]   cur_chn;
   logic               pkt_done;
   logic               drop;
   logic               trunc_err;
   logic               len_err;

   // master: the environment feeding the stream and owning channel readiness
   modport master (
      output din, din_vld, din_sop, din_eop, chn_rdy,
      input  din_rdy, dout, dout_vld, dout_sop, dout_eop,
      input  cur_chn, pkt_done, drop, trunc_err, len_err
   );

   // slave: the dispatcher itself
   modport slave (
      input  din, din_vld, din_sop, din_eop, chn_rdy,
      output din_rdy, dout, dout_vld, dout_sop, dout_eop,
      output cur_chn, pkt_done, drop, trunc_err, len_err
   );
endinterface

// File: rtl/rr_packet_dispatcher.sv
// Round-robin whole-packet dispatcher: one framed input stream to CHN_NUM output channels.
// Optional length checking is enabled by defining DISPATCH_LEN_CHK_EN.
module rr_packet_dispatcher #(
   parameter int CHN_NUM = 8,
   parameter int CHN_W   = 3,
   parameter int DATA_W  = 8,
   parameter int PKT_LEN = 188,
   parameter int CNT_W   = 8
) (
   input logic                clk,
   input logic                rst,
   rr_packet_dispatcher_if.slave bus
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_XFER = 1'b1;

   generate
      if (CHN_NUM < 2 || CHN_NUM > 16 || CHN_W != $clog2(CHN_NUM) || (2 ** CNT_W) <= PKT_LEN) begin : g_bad_cfg
         $error("rr_packet_dispatcher: inconsistent CHN_NUM/CHN_W/CNT_W/PKT_LEN");
      end
   endgenerate

   logic [0:0]         state_q, state_d;
   logic [CHN_W-1:0]   last_chn_q, last_chn_d;
   logic [CHN_W-1:0]   cur_chn_q, cur_chn_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic [CHN_NUM-1:0] dout_vld_q, dout_vld_d;
   logic               dout_sop_q, dout_sop_d;
   logic               dout_eop_q, dout_eop_d;
   logic               pkt_done_q, pkt_done_d;
   logic               drop_q, drop_d;
   logic               trunc_q, trunc_d;
   logic               len_err_d;
   logic               pkt_end;

   logic [CHN_W-1:0]   win_chn;
   logic [CHN_W-1:0]   srch_idx;
   logic               any_rdy;
   logic               din_rdy;
   logic               accept;
   logic               fwd;

   // Descending scan so the nearest channel after last_chn is written last and wins.
   always_comb begin
      win_chn  = '0;
      srch_idx = '0;
      any_rdy  = 1'b0;
      for (int i = CHN_NUM; i >= 1; i--) begin
         srch_idx = CHN_W'((int'(last_chn_q) + i) % CHN_NUM);
         if (bus.chn_rdy[srch_idx]) begin
            win_chn = srch_idx;
            any_rdy = 1'b1;
         end
      end
   end

   always_comb begin
      if (state_q == S_IDLE) din_rdy = !bus.din_sop || any_rdy;
      else                   din_rdy = !bus.din_sop && bus.chn_rdy[cur_chn_q];
   end

   assign accept = bus.din_vld && din_rdy;

`ifdef DISPATCH_LEN_CHK_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             len_err_q;
`endif

   always_comb begin
      state_d    = state_q;
      last_chn_d = last_chn_q;
      cur_chn_d  = cur_chn_q;
      dout_d     = dout_q;
      dout_vld_d = '0;
      dout_sop_d = 1'b0;
      dout_eop_d = 1'b0;
      pkt_done_d = 1'b0;
      drop_d     = 1'b0;
      trunc_d    = 1'b0;
      len_err_d  = 1'b0;
      pkt_end    = 1'b0;
      fwd        = 1'b0;
`ifdef DISPATCH_LEN_CHK_EN
      cnt_d      = cnt_q;
`endif
      if (state_q == S_IDLE) begin
         if (accept && !bus.din_sop) begin
            drop_d = 1'b1;
         end else if (accept) begin
            fwd        = 1'b1;
            last_chn_d = win_chn;
            cur_chn_d  = win_chn;
            dout_sop_d = 1'b1;
         end
      end else begin
         // A sop mid-packet abandons the current packet; IDLE picks it up next cycle.
         if (bus.din_vld && bus.din_sop) begin
            trunc_d = 1'b1;
            state_d = S_IDLE;
         end else if (accept) begin
            fwd = 1'b1;
         end
      end

      if (fwd) begin
         dout_d                = bus.din;
         dout_vld_d[cur_chn_d] = 1'b1;
`ifdef DISPATCH_LEN_CHK_EN
         cnt_d = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
         if (bus.din_eop) begin
            pkt_end   = 1'b1;
            len_err_d = (cnt_d != CNT_W'(PKT_LEN));
         end else if (cnt_d == CNT_W'(PKT_LEN)) begin
            pkt_end   = 1'b1;
            len_err_d = 1'b1;
         end
`else
         pkt_end = bus.din_eop;
`endif
         dout_eop_d = pkt_end;
         pkt_done_d = pkt_end;
         state_d    = pkt_end ? S_IDLE : S_XFER;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         last_chn_q <= CHN_W'(CHN_NUM - 1);
         cur_chn_q  <= '0;
         dout_q     <= '0;
         dout_vld_q <= '0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
         pkt_done_q <= 1'b0;
         drop_q     <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_chn_q <= last_chn_d;
         cur_chn_q  <= cur_chn_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         dout_sop_q <= dout_sop_d;
         dout_eop_q <= dout_eop_d;
         pkt_done_q <= pkt_done_d;
         drop_q     <= drop_d;
         trunc_q    <= trunc_d;
      end
   end

`ifdef DISPATCH_LEN_CHK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end
   assign bus.len_err = len_err_q;
`else
   assign bus.len_err = 1'b0;
`endif

   assign bus.din_rdy   = din_rdy;
   assign bus.dout      = dout_q;
   assign bus.dout_vld  = dout_vld_q;
   assign bus.dout_sop  = dout_sop_q;
   assign bus.dout_eop  = dout_eop_q;
   assign bus.cur_chn   = cur_chn_q;
   assign bus.pkt_done  = pkt_done_q;
   assign bus.drop      = drop_q;
   assign bus.trunc_err = trunc_q;
endmodule

// File: tb/tb_rr_packet_dispatcher.sv
// Scoreboard bench for rr_packet_dispatcher: expected egress beats are queued when a beat
// is accepted and compared as they appear one cycle later.
module tb_rr_packet_dispatcher;
   localparam int CHN_NUM = 8;
   localparam int CHN_W   = 3;
   localparam int DATA_W  = 8;
   localparam int PKT_LEN = 188;
   localparam int CNT_W   = 8;

   typedef struct {
      logic [DATA_W-1:0]  data;
      logic [CHN_NUM-1:0] vld;
      logic               sop;
      logic               eop;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pd     = 0;
   int   n_drop   = 0;
   int   n_trunc  = 0;
   int   n_len    = 0;

   rr_packet_dispatcher_if #(.CHN_NUM(CHN_NUM), .CHN_W(CHN_W), .DATA_W(DATA_W)) bus ();

   rr_packet_dispatcher #(
      .CHN_NUM(CHN_NUM), .CHN_W(CHN_W), .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Egress monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.dout_vld != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_vld", 32'(bus.dout_vld), 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               $display("beat data=%02h vld=%08b sop=%0b eop=%0b (exp data=%02h vld=%08b)",
                        bus.dout, bus.dout_vld, bus.dout_sop, bus.dout_eop, e.data, e.vld);
               check("dout", 32'(bus.dout), 32'(e.data));
               check("dout_vld", 32'(bus.dout_vld), 32'(e.vld));
               check("dout_sop", 32'(bus.dout_sop), 32'(e.sop));
               check("dout_eop", 32'(bus.dout_eop), 32'(e.eop));
            end
         end
         if (bus.pkt_done)  n_pd++;
         if (bus.drop)      n_drop++;
         if (bus.trunc_err) n_trunc++;
         if (bus.len_err)   n_len++;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic send_beat(input logic [7:0] d, input logic s, input logic e,
                            input logic fwd, input logic e_eop, input int chn);
      int   n;
      exp_t x;
      bus.din     = d;
      bus.din_sop = s;
      bus.din_eop = e;
      bus.din_vld = 1'b1;
      n = 0;
      #1;
      while (!bus.din_rdy && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!bus.din_rdy) begin
         check("rdy_timeout", 32'(bus.din_rdy), 32'h1);
      end else if (fwd) begin
         x.data = d;
         x.vld  = CHN_NUM'(1) << chn;
         x.sop  = s;
         x.eop  = e_eop;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      bus.din_vld = 1'b0;
   endtask

   task automatic send_pkt(input int len, input logic [7:0] base, input int chn);
      for (int i = 0; i < len; i++)
         send_beat(base + 8'(i), i == 0, i == len - 1, 1'b1, i == len - 1, chn);
   endtask

   task automatic checkpoint(input string tag, input int e_pd, input int e_drop,
                             input int e_trunc, input int e_len);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
      check({tag, "_pkt_done"}, 32'(n_pd), 32'(e_pd));
      check({tag, "_drop"}, 32'(n_drop), 32'(e_drop));
      check({tag, "_trunc"}, 32'(n_trunc), 32'(e_trunc));
      check({tag, "_len_err"}, 32'(n_len), 32'(e_len));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog sim did not finish got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      bus.din     = '0;
      bus.din_vld = 1'b0;
      bus.din_sop = 1'b0;
      bus.din_eop = 1'b0;
      bus.chn_rdy = '1;
      repeat (2) @(negedge clk);
      check("rst_dout", 32'(bus.dout), 32'h0);
      check("rst_dout_vld", 32'(bus.dout_vld), 32'h0);
      check("rst_sop_eop", {30'h0, bus.dout_sop, bus.dout_eop}, 32'h0);
      check("rst_cur_chn", 32'(bus.cur_chn), 32'h0);
      check("rst_pulses", {28'h0, bus.pkt_done, bus.drop, bus.trunc_err, bus.len_err}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Four packets, all channels ready: 0,1,2,3
      for (int p = 0; p < 4; p++) send_pkt(4, 8'(8'h10 * (p + 1)), p);
      checkpoint("rr_all", 4, 0, 0, 0);

      // Sparse readiness and wrap-around
      bus.chn_rdy = 8'b0000_0100;
      send_pkt(3, 8'h80, 2);
      bus.chn_rdy = 8'b0010_0100;
      send_pkt(3, 8'h90, 5);
      send_pkt(3, 8'hA0, 2);
      checkpoint("rr_wrap", 7, 0, 0, 0);

      // Sop stalled with no channel ready
      bus.chn_rdy = '0;
      bus.din     = 8'h30;
      bus.din_sop = 1'b1;
      bus.din_eop = 1'b0;
      bus.din_vld = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_rdy", 32'(bus.din_rdy), 32'h0);
         @(posedge clk);
         #1;
      end
      check("stall_cur_chn", 32'(bus.cur_chn), 32'h2);
      bus.chn_rdy = 8'b0000_1000;
      send_beat(8'h30, 1'b1, 1'b0, 1'b1, 1'b0, 3);
      check("grant_cur_chn", 32'(bus.cur_chn), 32'h3);
      for (int b = 1; b < 4; b++) begin
         bus.chn_rdy = 8'b1111_0111;
         bus.din     = 8'h30 + 8'(b);
         bus.din_sop = 1'b0;
         bus.din_eop = (b == 3);
         bus.din_vld = 1'b1;
         #1;
         check("toggle_rdy_low", 32'(bus.din_rdy), 32'h0);
         repeat (2) @(posedge clk);
         #1;
         bus.chn_rdy = 8'b0000_1000;
         send_beat(8'h30 + 8'(b), 1'b0, b == 3, 1'b1, b == 3, 3);
      end
      checkpoint("stall", 8, 0, 0, 0);

      // Drops in IDLE, then truncation by an early sop
      bus.chn_rdy = '1;
      for (int k = 0; k < 3; k++) send_beat(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_beat(8'h50, 1'b1, 1'b0, 1'b1, 1'b0, 4);
      send_beat(8'h51, 1'b0, 1'b0, 1'b1, 1'b0, 4);
      send_pkt(4, 8'h60, 5);
      checkpoint("trunc", 9, 3, 1, 0);

      // Single-beat packet; following non-sop beat must be dropped (still IDLE)
      send_beat(8'h47, 1'b1, 1'b1, 1'b1, 1'b1, 6);
      send_beat(8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkpoint("single", 10, 4, 1, 0);

`ifdef DISPATCH_LEN_CHK_EN
      // Overlong packet: eop forced on beat PKT_LEN, remaining beats dropped
      for (int i = 0; i < PKT_LEN + 2; i++) begin
         if (i < PKT_LEN)
            send_beat(8'(i), i == 0, 1'b0, 1'b1, i == PKT_LEN - 1, 7);
         else
            send_beat(8'(i), 1'b0, i == PKT_LEN + 1, 1'b0, 1'b0, 0);
      end
      checkpoint("len_long", 11, 6, 1, 1);
      send_pkt(100, 8'h00, 0);
      checkpoint("len_short", 12, 6, 1, 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
